// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 valid/ready stream mux with round-robin arbitration
// and a single registered output stage.
// Optional packet lock (holds the grant on one channel until in_last) is
// compiled in when STREAM_MUX_LOCK_EN is defined; the default build has no
// lock FSM and ties out_last to 0.
module stream_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_last,
  input  logic                 out_ready
);

  logic            load;
  logic            accept;
  logic            gnt_vld;
  logic            adv;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_nxt;

  assign load   = !out_valid || out_ready;
  assign accept = gnt_vld && load;
  assign rr_nxt = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);

`ifdef STREAM_MUX_LOCK_EN
  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]      state;
  logic [SELW-1:0] lock_ch;
  logic            out_last_q;

  // pointer only moves when a packet completes, so a locked packet does not
  // cost the next channel its turn
  assign adv      = in_last[grant];
  assign out_last = out_last_q;

  // packet lock: enter on a non-last accept, leave on the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      lock_ch <= '0;
    end else if (accept) begin
      if (!in_last[grant]) begin
        state   <= LOCKED;
        lock_ch <= grant;
      end else begin
        state   <= ARB;
      end
    end
  end

  // last flag travels with the beat through the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_last_q <= 1'b0;
    else if (accept) out_last_q <= in_last[grant];
  end
`else
  logic unused_in_last;

  assign adv            = 1'b1;
  assign out_last       = 1'b0;
  assign unused_in_last = ^in_last;
`endif

  // round-robin search from rr_ptr, wrapping; reverse scan so the nearest
  // valid channel to rr_ptr is the last (winning) assignment
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (in_valid[idx]) begin
        grant   = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    if (state == LOCKED) begin
      grant   = lock_ch;
      gnt_vld = in_valid[lock_ch];
    end
`endif
  end

  // one-hot ready to the granted channel only when the output can load
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = accept && (grant == SELW'(i));
  end

  // round-robin pointer: next search starts just past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rr_ptr <= '0;
    else if (accept && adv) rr_ptr <= rr_nxt;
  end

  // output register: reload on accept, clear valid on drain, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n (N=4, WIDTH=32): directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-free behavioural model of the arbitration rules.
module tb_stream_mux_n;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_last;
  logic           out_ready = 1'b0;

  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_ready(out_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel, m_ptr, m_lock;
  bit           m_last, m_locked;
  logic [N-1:0] acc = '0;   // channels the model says accept at the next edge

  // compare process: inputs are stable at negedge+1, outputs reflect last edge
  always @(negedge clk) begin
    int g;
    bit ld;
    logic [N-1:0] er;
    #1;
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_last = 0;
      m_ptr = 0; m_locked = 0; m_lock = 0; acc = '0;
    end else begin
      g = -1;
      if (m_locked) begin
        if (in_valid[m_lock]) g = m_lock;
      end else begin
        for (int k = N-1; k >= 0; k--)
          if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      ld = !m_valid || out_ready;
      er = '0;
      if (g >= 0 && ld) er[g] = 1'b1;
      chk("in_ready",  in_ready,  er);
      chk("out_valid", out_valid, m_valid);
      chk("out_data",  out_data,  m_data);
      chk("out_sel",   out_sel,   m_sel);
      chk("out_last",  out_last,  m_last);
      acc = er;
      if (er != '0) begin
        m_valid = 1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
`ifdef STREAM_MUX_LOCK_EN
        m_last = in_last[g];
        if (in_last[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
        else begin m_locked = 1; m_lock = g; end
`else
        m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  logic [W-1:0] dnext [N];

  // one cycle of stimulus; a channel keeps its beat until the model saw it taken
  task automatic cycle(input logic [N-1:0] want, input logic r,
                       input logic [N-1:0] lastv);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!in_valid[i] || acc[i]) begin
        in_valid[i]       = want[i];
        in_data[i*W +: W] = dnext[i];
        in_last[i]        = lastv[i];
        dnext[i]          = $urandom;
      end
    out_ready = r;
    #2;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((in_valid != '0 || out_valid) && t < 20) begin
      cycle('0, 1'b1, '0);
      t++;
    end
    chk("idle_in_valid", in_valid, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  logic [N-1:0] sp_rdy [4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
  int sp_sel [4] = '{3, 0, 3, 0};

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) dnext[i] = $urandom;
    // power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_sel",   out_sel,   0);
    chk("rst_out_last",  out_last,  0);
    @(posedge clk); #1 rst = 1'b0;

    // fill, then async reset mid-cycle with a beat held
    repeat (3) cycle('1, 1'b1, '1);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data",  out_data,  0);
    chk("async_rst_sel",   out_sel,   0);
    chk("async_rst_last",  out_last,  0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // round robin with everyone valid; first grant after reset is channel 0
    cycle('1, 1'b1, '1);
    chk("rr_first_grant", in_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      cycle('1, 1'b1, '1);
      chk("rr_valid", out_valid, 1);
      chk($sformatf("rr_sel%0d", k), out_sel, rr_exp[k]);
    end
    drain();

    // backpressure on channel 2
    dnext[2] = 32'hDEADBEEF;
    cycle(4'b0100, 1'b0, 4'b0100);
    chk("bp_first_ready", in_ready, 4'b0100);
    dnext[2] = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0100, 1'b0, 4'b0100);
      chk("bp_valid", out_valid, 1);
      chk("bp_data",  out_data,  32'hDEADBEEF);
      chk("bp_ready", in_ready,  0);
    end
    cycle(4'b0100, 1'b1, 4'b0100);
    chk("bp_release_ready", in_ready, 4'b0100);
    cycle('0, 1'b1, '0);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data",  out_data,  32'h12345678);

    // sparse channels 3 and 0 starting from pointer 3
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1001, 1'b1, '1);
      if (k < 4) chk($sformatf("sp_ready%0d", k), in_ready, sp_rdy[k]);
      if (k > 0) chk($sformatf("sp_sel%0d", k-1), out_sel, sp_sel[k-1]);
    end
    drain();

`ifdef STREAM_MUX_LOCK_EN
    // channel 1 sends a 3-beat packet while channel 2 waits
    cycle(4'b0010, 1'b1, 4'b0000);
    chk("lk_ready0", in_ready, 4'b0010);
    cycle(4'b0110, 1'b1, 4'b0100);
    chk("lk_ready1", in_ready, 4'b0010);
    chk("lk_sel0", out_sel, 1);
    cycle(4'b0110, 1'b1, 4'b0110);
    chk("lk_ready2", in_ready, 4'b0010);
    chk("lk_sel1", out_sel, 1);
    cycle(4'b0100, 1'b1, 4'b0100);
    chk("lk_ready3", in_ready, 4'b0100);
    chk("lk_sel2", out_sel, 1);
    chk("lk_last", out_last, 1);
    cycle('0, 1'b1, '0);
    chk("lk_sel3", out_sel, 2);
    drain();
`endif

    // randomized traffic and backpressure
    repeat (400) cycle(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
